// File: rtl/mem_stage_pkg.sv
// Shared types for the RV32I MEM stage: instruction short codes, access lengths and FSM states.
package mem_stage_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [4:0] {
        INST_NOP = 5'd0,
        INST_ADD,
        INST_SUB,
        INST_AND,
        INST_OR,
        INST_XOR,
        INST_LB,
        INST_LH,
        INST_LW,
        INST_LBU,
        INST_LHU,
        INST_SB,
        INST_SH,
        INST_SW
    } inst_short_t;

    typedef enum logic [1:0] {
        LEN_BYTE = 2'd0,
        LEN_HALF = 2'd1,
        LEN_WORD = 2'd2
    } mem_len_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } mem_state_t;

    function automatic logic is_load(input inst_short_t inst);
        return inst inside {INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU};
    endfunction

    function automatic logic is_store(input inst_short_t inst);
        return inst inside {INST_SB, INST_SH, INST_SW};
    endfunction

    function automatic mem_len_t access_len(input inst_short_t inst);
        case (inst)
            INST_LB, INST_LBU, INST_SB: return LEN_BYTE;
            INST_LH, INST_LHU, INST_SH: return LEN_HALF;
            default:                    return LEN_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Request/done bus between the MEM stage (master) and the memory controller (slave).
interface mem_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_len;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_len,
        input  mem_rdata, mem_done
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_len,
        output mem_rdata, mem_done
    );
endinterface

// File: rtl/mem_stage_load_ext.sv
// Sign/zero extension of raw load data (bytes packed at LSB) according to the load type.
module load_ext
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  inst_short_t       inst,
    input  logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] ext
);
    always_comb begin
        case (inst)
            INST_LB:  ext = {{(DATA_W-8){raw[7]}}, raw[7:0]};
            INST_LBU: ext = {{(DATA_W-8){1'b0}}, raw[7:0]};
            INST_LH:  ext = {{(DATA_W-16){raw[15]}}, raw[15:0]};
            INST_LHU: ext = {{(DATA_W-16){1'b0}}, raw[15:0]};
            default:  ext = raw;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage RV32I pipeline: loads/stores over a req/done bus, stall while busy.
// Optional macro MEM_FWD_EN adds fwd_valid/fwd_rd_address/fwd_rd_data bypass outputs toward id.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  hold_in,
    input  logic [REG_ADDR_W-1:0] rd_address_in,
    input  logic [DATA_W-1:0]     rd_data_in,
    input  inst_short_t           inst_in,
    input  logic [ADDR_W-1:0]     mem_address_in,
    mem_stage_if.master           mem,
    output logic                  stall_req,
    output logic [REG_ADDR_W-1:0] rd_address,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_enable
`ifdef MEM_FWD_EN
    ,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd_address,
    output logic [DATA_W-1:0]     fwd_rd_data
`endif
);

    mem_state_t        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    mem_len_t          mem_len_q, mem_len_d;
    inst_short_t       inst_q, inst_d;
    logic [DATA_W-1:0] load_data_q, load_data_d;
    logic [DATA_W-1:0] ext_data;

    // Extension uses the instruction captured at issue, independent of what ex_mem shows later.
    load_ext #(.DATA_W(DATA_W)) u_load_ext (
        .inst (inst_q),
        .raw  (mem.mem_rdata),
        .ext  (ext_data)
    );

    always_comb begin
        // NOTE: every _d takes its _q value first so no path through the case infers a latch.
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_len_d   = mem_len_q;
        inst_d      = inst_q;
        load_data_d = load_data_q;
        if (rdy_in) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_load(inst_in) || is_store(inst_in)) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store(inst_in);
                        mem_addr_d  = mem_address_in;
                        mem_wdata_d = rd_data_in;
                        mem_len_d   = access_len(inst_in);
                        inst_d      = inst_in;
                        state_d     = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mem.mem_done) begin
                        mem_req_d   = 1'b0;
                        load_data_d = ext_data;
                        state_d     = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!hold_in) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        // NOTE: non-blocking assignments so every flop updates from the same pre-edge values.
        if (rst_in) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_len_q   <= LEN_BYTE;
            inst_q      <= INST_NOP;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_len_q   <= mem_len_d;
            inst_q      <= inst_d;
            load_data_q <= load_data_d;
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_len   = mem_len_q;

    // Writeback view: passthrough in IDLE, stall until the access finishes, load result in DONE.
    always_comb begin
        stall_req  = 1'b0;
        rd_enable  = 1'b0;
        rd_address = rd_address_in;
        rd_data    = rd_data_in;
        case (state_q)
            ST_IDLE: begin
                if (is_load(inst_in) || is_store(inst_in)) begin
                    stall_req = 1'b1;
                end else if (inst_in == INST_NOP) begin
                    rd_address = '0;
                    rd_data    = '0;
                end else begin
                    rd_enable = (rd_address_in != '0);
                end
            end
            ST_BUSY: stall_req = 1'b1;
            ST_DONE: begin
                if (!mem_we_q) begin
                    rd_data   = load_data_q;
                    rd_enable = (rd_address_in != '0);
                end
            end
            default: stall_req = 1'b0;
        endcase
    end

`ifdef MEM_FWD_EN
    assign fwd_valid      = rd_enable && !stall_req;
    assign fwd_rd_address = rd_address;
    assign fwd_rd_data    = rd_data;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a hand-driven memory controller.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        hold_in;
    logic [4:0]  rd_address_in;
    logic [31:0] rd_data_in;
    inst_short_t inst_in;
    logic [31:0] mem_address_in;
    logic        stall_req;
    logic [4:0]  rd_address;
    logic [31:0] rd_data;
    logic        rd_enable;
`ifdef MEM_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd_address;
    logic [31:0] fwd_rd_data;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int stalls;
    logic [31:0] held_data;

    mem_stage_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

    mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .hold_in        (hold_in),
        .rd_address_in  (rd_address_in),
        .rd_data_in     (rd_data_in),
        .inst_in        (inst_in),
        .mem_address_in (mem_address_in),
        .mem            (mem_bus),
        .stall_req      (stall_req),
        .rd_address     (rd_address),
        .rd_data        (rd_data),
        .rd_enable      (rd_enable)
`ifdef MEM_FWD_EN
        ,
        .fwd_valid      (fwd_valid),
        .fwd_rd_address (fwd_rd_address),
        .fwd_rd_data    (fwd_rd_data)
`endif
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic go_idle();
        hold_in       = 1'b0;
        inst_in       = INST_NOP;
        rd_address_in = 5'd0;
        rd_data_in    = 32'd0;
        tick();
        #1;
    endtask

    // Presents a load/store, checks the request bus while stalled, pulses mem_done in cycle
    // done_cycle (issue cycle = 0) and returns in the first non-stalled cycle.
    task automatic run_access(input inst_short_t inst, input logic [4:0] rd,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic exp_we, input logic [1:0] exp_len,
                              input int done_cycle, input logic [31:0] rdata,
                              output int n_stall);
        inst_in          = inst;
        rd_address_in    = rd;
        mem_address_in   = addr;
        rd_data_in       = wdata;
        mem_bus.mem_done  = 1'b0;
        mem_bus.mem_rdata = rdata;
        #1;
        n_stall = 0;
        for (int c = 0; c < done_cycle + 4; c++) begin
            if (!stall_req) break;
            n_stall++;
            check("stall_rd_en", rd_enable, 1'b0);
            if (c > 0) begin
                check("busy_req", mem_bus.mem_req, 1'b1);
                check("busy_we", mem_bus.mem_we, exp_we);
                check("busy_addr", mem_bus.mem_addr, addr);
                check("busy_wdata", mem_bus.mem_wdata, wdata);
                check("busy_len", mem_bus.mem_len, exp_len);
            end
            tick();
            mem_bus.mem_done = (c + 1 == done_cycle);
            #1;
        end
        check("done_stall", stall_req, 1'b0);
        check("done_req", mem_bus.mem_req, 1'b0);
    endtask

    initial begin
        rst_in            = 1'b1;
        rdy_in            = 1'b1;
        hold_in           = 1'b0;
        inst_in           = INST_NOP;
        rd_address_in     = 5'd0;
        rd_data_in        = 32'd0;
        mem_address_in    = 32'd0;
        mem_bus.mem_done  = 1'b0;
        mem_bus.mem_rdata = 32'd0;
        tick();
        tick();
        rst_in = 1'b0;
        #1;

        check("rst_req", mem_bus.mem_req, 1'b0);
        check("rst_we", mem_bus.mem_we, 1'b0);
        check("rst_addr", mem_bus.mem_addr, 32'd0);
        check("rst_wdata", mem_bus.mem_wdata, 32'd0);
        check("rst_len", mem_bus.mem_len, 2'd0);
        check("rst_rd_addr", rd_address, 5'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_rd_en", rd_enable, 1'b0);
        check("rst_stall", stall_req, 1'b0);

        // ALU passthrough with zero latency
        inst_in = INST_ADD; rd_address_in = 5'd5; rd_data_in = 32'h1234;
        #1;
        check("add_rd_en", rd_enable, 1'b1);
        check("add_rd_addr", rd_address, 5'd5);
        check("add_rd_data", rd_data, 32'h1234);
        check("add_stall", stall_req, 1'b0);
`ifdef MEM_FWD_EN
        check("add_fwd_valid", fwd_valid, 1'b1);
        check("add_fwd_data", fwd_rd_data, 32'h1234);
`endif
        tick();
        #1;
        check("add_no_req", mem_bus.mem_req, 1'b0);
        inst_in = INST_SUB; rd_address_in = 5'd0; rd_data_in = 32'h55;
        #1;
        check("sub_x0_rd_en", rd_enable, 1'b0);
        go_idle();

        // LB sign extension, done in cycle 4 -> stall for 5 cycles
        run_access(INST_LB, 5'd7, 32'h100, 32'h0, 1'b0, 2'd0, 4, 32'h0000_00F0, stalls);
        check("lb_stall_cycles", stalls, 5);
        check("lb_rd_data", rd_data, 32'hFFFF_FFF0);
        check("lb_rd_en", rd_enable, 1'b1);
        check("lb_rd_addr", rd_address, 5'd7);
        go_idle();

        run_access(INST_LBU, 5'd7, 32'h100, 32'h0, 1'b0, 2'd0, 4, 32'h0000_00F0, stalls);
        check("lbu_rd_data", rd_data, 32'h0000_00F0);
        go_idle();

        run_access(INST_LH, 5'd9, 32'h202, 32'h0, 1'b0, 2'd1, 2, 32'h0000_8001, stalls);
        check("lh_stall_cycles", stalls, 3);
        check("lh_rd_data", rd_data, 32'hFFFF_8001);
        go_idle();

        run_access(INST_LHU, 5'd9, 32'h202, 32'h0, 1'b0, 2'd1, 2, 32'h0000_8001, stalls);
        check("lhu_rd_data", rd_data, 32'h0000_8001);
        go_idle();

        // Load to x0 still performs the access but never writes rd
        run_access(INST_LW, 5'd0, 32'h404, 32'h0, 1'b0, 2'd2, 2, 32'hDEAD_BEEF, stalls);
        check("lw_x0_stalls", stalls, 3);
        check("lw_x0_rd_en", rd_enable, 1'b0);
        go_idle();

        // Store: request fields are checked every busy cycle inside run_access
        run_access(INST_SH, 5'd3, 32'h2002, 32'hABCD_1234, 1'b1, 2'd1, 3, 32'h0, stalls);
        check("sh_stall_cycles", stalls, 4);
        check("sh_rd_en", rd_enable, 1'b0);
        go_idle();

        // LW completes while ex_mem is held for 3 cycles
        run_access(INST_LW, 5'd12, 32'h3000, 32'h0, 1'b0, 2'd2, 3, 32'hCAFE_F00D, stalls);
        hold_in = 1'b1;
        mem_bus.mem_rdata = 32'h1111_2222;
        #1;
        held_data = rd_data;
        check("hold_rd_data", held_data, 32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            check("hold_no_reissue", mem_bus.mem_req, 1'b0);
            check("hold_stall", stall_req, 1'b0);
            check("hold_data_stable", rd_data, held_data);
            check("hold_rd_en", rd_enable, 1'b1);
        end
        go_idle();
        check("after_hold_idle_req", mem_bus.mem_req, 1'b0);

        // Reset during BUSY, then a stray mem_done
        inst_in = INST_LW; rd_address_in = 5'd4; mem_address_in = 32'h44;
        tick();
        tick();
        #1;
        check("rst_busy_req", mem_bus.mem_req, 1'b1);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        inst_in = INST_NOP; rd_address_in = 5'd0;
        #1;
        check("rst_busy_req_drop", mem_bus.mem_req, 1'b0);
        check("rst_busy_stall", stall_req, 1'b0);
        mem_bus.mem_done = 1'b1;
        mem_bus.mem_rdata = 32'h9999_9999;
        tick();
        mem_bus.mem_done = 1'b0;
        #1;
        check("stray_done_req", mem_bus.mem_req, 1'b0);
        check("stray_done_stall", stall_req, 1'b0);
        check("stray_done_rd_en", rd_enable, 1'b0);
        check("stray_done_rd_data", rd_data, 32'd0);

        // rdy_in low for 2 cycles in BUSY freezes the request
        inst_in = INST_SW; rd_address_in = 5'd6; mem_address_in = 32'h5001; rd_data_in = 32'h0BAD_F00D;
        tick();
        #1;
        check("rdy_busy_req", mem_bus.mem_req, 1'b1);
        rdy_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            check("frz_req", mem_bus.mem_req, 1'b1);
            check("frz_we", mem_bus.mem_we, 1'b1);
            check("frz_addr", mem_bus.mem_addr, 32'h5001);
            check("frz_wdata", mem_bus.mem_wdata, 32'h0BAD_F00D);
            check("frz_len", mem_bus.mem_len, 2'd2);
            check("frz_stall", stall_req, 1'b1);
        end
        rdy_in = 1'b1;
        mem_bus.mem_done = 1'b1;
        tick();
        mem_bus.mem_done = 1'b0;
        #1;
        check("rdy_done_req", mem_bus.mem_req, 1'b0);
        check("rdy_done_stall", stall_req, 1'b0);
        check("rdy_done_rd_en", rd_enable, 1'b0);
        go_idle();
        check("final_idle_stall", stall_req, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
